// File: rtl/crcu_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : crcu_rst_sequencer
// Description : Staged reset-release sequencer for the Clock & Reset Control
//               Unit. Holds every peripheral reset domain in reset while the
//               upstream reset request (rst_in) is high. After rst_in falls it
//               releases the enabled domains one at a time, in index order,
//               with a programmable gap between releases.
//
// Ports       : CRCU_CLK   - single clock, rising-edge logic
//               CRCU_RST   - asynchronous active-high master reset
//               rst_in     - active-high reset request (sync to CRCU_CLK)
//               seq_gap    - inter-stage gap in cycles (captured on HOLD exit)
//               domain_en  - per-domain enable mask (captured on HOLD exit)
//               rst_out    - registered active-high per-domain resets
//               seq_busy   - release sequence in progress
//               seq_done   - sequence complete, sticky until next reset
//               seq_stage  - index of the domain currently being processed
//
// Revision    : 1.0 - initial release
// ============================================================================
module crcu_rst_sequencer #(
   parameter int NUM_DOMAINS = 4,
   parameter int GAP_W       = 8,
   parameter int IDX_W       = $clog2(NUM_DOMAINS)
) (
   input  logic                   CRCU_CLK,
   input  logic                   CRCU_RST,
   input  logic                   rst_in,
   input  logic [GAP_W-1:0]       seq_gap,
   input  logic [NUM_DOMAINS-1:0] domain_en,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   seq_busy,
   output logic                   seq_done,
   output logic [IDX_W-1:0]       seq_stage
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_HOLD = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [GAP_W-1:0]       r_cnt;
   logic [GAP_W-1:0]       r_gap_q;
   logic [NUM_DOMAINS-1:0] r_en_q;
   logic [NUM_DOMAINS-1:0] r_rst_out;
   logic                   r_busy;
   logic                   r_done;
   logic [IDX_W-1:0]       r_stage;

   // ------------------------------------------------------------------------
   // Stage decode
   // ------------------------------------------------------------------------
   logic             w_en_cur;
   logic             w_stage_end;
   logic             w_last;
   logic [IDX_W-1:0] w_idx_nxt;

   // The stage index never exceeds NUM_DOMAINS-1, so the mask lookup stays
   // in range even when NUM_DOMAINS is not a power of two.
   assign w_en_cur    = r_en_q[r_idx];

   // An enabled stage ends when the counter reaches the captured gap, giving
   // gap_q+1 cycles per stage; a disabled stage ends after a single cycle.
   // Because the compare is an equality at the same width as the counter,
   // the counter cannot wrap even for the all-ones gap.
   assign w_stage_end = w_en_cur ? (r_cnt == r_gap_q) : 1'b1;

   assign w_last      = (r_idx == c_LAST_IDX);
   assign w_idx_nxt   = r_idx + 1'b1;

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
      if (CRCU_RST) begin
         r_state   <= c_HOLD;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_gap_q   <= '0;
         r_en_q    <= '0;
         r_rst_out <= '1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_stage   <= '0;
      end else if (rst_in) begin
         // A reset request overrides whatever the sequencer is doing and
         // re-asserts every domain on this edge.
         r_state   <= c_HOLD;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_rst_out <= '1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_stage   <= '0;
      end else begin
         case (r_state)
            c_HOLD: begin
               // Snapshot the control inputs: later changes on seq_gap or
               // domain_en only matter at the next exit from HOLD.
               r_gap_q   <= seq_gap;
               r_en_q    <= domain_en;
               r_state   <= c_WAIT;
               r_idx     <= '0;
               r_cnt     <= '0;
               r_rst_out <= '1;
               r_busy    <= 1'b1;
               r_done    <= 1'b0;
               r_stage   <= '0;
            end

            c_WAIT: begin
               if (w_stage_end) begin
                  if (w_en_cur) begin
                     r_rst_out[r_idx] <= 1'b0;
                  end
                  r_cnt <= '0;
                  if (w_last) begin
                     r_state <= c_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_stage <= c_LAST_IDX;
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_stage <= w_idx_nxt;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            c_DONE: begin
               // Everything holds until rst_in or CRCU_RST.
               r_state <= c_DONE;
            end

            default: begin
               // Unused encoding: fall back to the safe, all-in-reset state.
               r_state   <= c_HOLD;
               r_idx     <= '0;
               r_cnt     <= '0;
               r_rst_out <= '1;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_stage   <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all straight from registers)
   // ------------------------------------------------------------------------
   assign rst_out   = r_rst_out;
   assign seq_busy  = r_busy;
   assign seq_done  = r_done;
   assign seq_stage = r_stage;

endmodule
`default_nettype wire

// File: tb/tb_crcu_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_crcu_rst_sequencer
// Description : Directed self-checking bench for crcu_rst_sequencer. Each
//               scenario task drives its stimulus and compares observed
//               release edges and status against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crcu_rst_sequencer;

   localparam int c_ND    = 4;
   localparam int c_GAP_W = 8;
   localparam int c_IDX_W = 2;

   logic               CRCU_CLK;
   logic               CRCU_RST;
   logic               rst_in;
   logic [c_GAP_W-1:0] seq_gap;
   logic [c_ND-1:0]    domain_en;
   logic [c_ND-1:0]    rst_out;
   logic               seq_busy;
   logic               seq_done;
   logic [c_IDX_W-1:0] seq_stage;

   int n_checks;
   int n_fail;

   // Observation results: edge offset from edge k (k = 0), -1 = never seen.
   int obs_fall [c_ND];
   int obs_done;
   int obs_err;

   crcu_rst_sequencer #(
      .NUM_DOMAINS (c_ND),
      .GAP_W       (c_GAP_W),
      .IDX_W       (c_IDX_W)
   ) u_dut (
      .CRCU_CLK  (CRCU_CLK),
      .CRCU_RST  (CRCU_RST),
      .rst_in    (rst_in),
      .seq_gap   (seq_gap),
      .domain_en (domain_en),
      .rst_out   (rst_out),
      .seq_busy  (seq_busy),
      .seq_done  (seq_done),
      .seq_stage (seq_stage)
   );

   initial CRCU_CLK = 1'b0;
   always #5 CRCU_CLK = ~CRCU_CLK;

   // Put the block through HOLD with the given controls, then drop rst_in so
   // that the next rising edge is edge k.
   task automatic start_seq(input logic [c_GAP_W-1:0] gap, input logic [c_ND-1:0] en);
      @(negedge CRCU_CLK);
      seq_gap   = gap;
      domain_en = en;
      rst_in    = 1'b1;
      @(negedge CRCU_CLK);
      rst_in    = 1'b0;
   endtask

   // Watch ncyc edges starting at edge k. Records first fall of each rst_out,
   // first rise of seq_done, and counts busy-status or re-assertion errors.
   task automatic observe(input int ncyc);
      for (int i = 0; i < c_ND; i++) obs_fall[i] = -1;
      obs_done = -1;
      obs_err  = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge CRCU_CLK);
         #1;
         for (int i = 0; i < c_ND; i++) begin
            if (obs_fall[i] >= 0 && rst_out[i] !== 1'b0) obs_err++;
            if (obs_fall[i] < 0 && rst_out[i] === 1'b0) obs_fall[i] = c;
         end
         if (obs_done < 0 && seq_done === 1'b1) obs_done = c;
         if (obs_done >= 0 && seq_done !== 1'b1) obs_err++;
         if (seq_busy !== (obs_done < 0)) obs_err++;
      end
   endtask

   task automatic test_reset;
      CRCU_RST  = 1'b1;
      rst_in    = 1'b1;
      seq_gap   = 8'd2;
      domain_en = 4'b1111;
      repeat (3) @(posedge CRCU_CLK);
      #1;
      n_checks++; if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL reset_rst_out got %b want 1111", rst_out); end
      n_checks++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", seq_busy); end
      n_checks++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", seq_done); end
      n_checks++; if (seq_stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage got %0d want 0", seq_stage); end
      @(negedge CRCU_CLK);
      CRCU_RST = 1'b0;
      repeat (3) @(posedge CRCU_CLK);
      #1;
      n_checks++; if (rst_out !== 4'b1111 || seq_busy !== 1'b0) begin n_fail++; $display("FAIL hold_after_reset rst_out=%b busy=%b want 1111/0", rst_out, seq_busy); end
   endtask

   task automatic test_full_sequence;
      start_seq(8'd2, 4'b1111);
      observe(16);
      n_checks++; if (obs_fall[0] != 3)  begin n_fail++; $display("FAIL full_fall0 got %0d want 3", obs_fall[0]); end
      n_checks++; if (obs_fall[1] != 6)  begin n_fail++; $display("FAIL full_fall1 got %0d want 6", obs_fall[1]); end
      n_checks++; if (obs_fall[2] != 9)  begin n_fail++; $display("FAIL full_fall2 got %0d want 9", obs_fall[2]); end
      n_checks++; if (obs_fall[3] != 12) begin n_fail++; $display("FAIL full_fall3 got %0d want 12", obs_fall[3]); end
      n_checks++; if (obs_done != 12)    begin n_fail++; $display("FAIL full_done got %0d want 12", obs_done); end
      n_checks++; if (obs_err != 0)      begin n_fail++; $display("FAIL full_status errors got %0d want 0", obs_err); end
      n_checks++; if (seq_stage !== 2'd3) begin n_fail++; $display("FAIL full_stage_done got %0d want 3", seq_stage); end
      n_checks++; if (rst_out !== 4'b0000) begin n_fail++; $display("FAIL full_final_rst got %b want 0000", rst_out); end
   endtask

   task automatic test_masked;
      start_seq(8'd2, 4'b1101);
      observe(14);
      n_checks++; if (obs_fall[0] != 3)  begin n_fail++; $display("FAIL mask_fall0 got %0d want 3", obs_fall[0]); end
      n_checks++; if (obs_fall[1] != -1) begin n_fail++; $display("FAIL mask_fall1 got %0d want never(-1)", obs_fall[1]); end
      n_checks++; if (obs_fall[2] != 7)  begin n_fail++; $display("FAIL mask_fall2 got %0d want 7", obs_fall[2]); end
      n_checks++; if (obs_fall[3] != 10) begin n_fail++; $display("FAIL mask_fall3 got %0d want 10", obs_fall[3]); end
      n_checks++; if (obs_done != 10)    begin n_fail++; $display("FAIL mask_done got %0d want 10", obs_done); end
      n_checks++; if (obs_err != 0)      begin n_fail++; $display("FAIL mask_status errors got %0d want 0", obs_err); end
   endtask

   task automatic test_gap_zero;
      start_seq(8'd0, 4'b1111);
      observe(8);
      n_checks++; if (obs_fall[0] != 1 || obs_fall[1] != 2 || obs_fall[2] != 3 || obs_fall[3] != 4) begin
         n_fail++; $display("FAIL gap0_falls got %0d,%0d,%0d,%0d want 1,2,3,4", obs_fall[0], obs_fall[1], obs_fall[2], obs_fall[3]);
      end
      n_checks++; if (obs_done != 4) begin n_fail++; $display("FAIL gap0_done got %0d want 4", obs_done); end
      n_checks++; if (obs_err != 0)  begin n_fail++; $display("FAIL gap0_status errors got %0d want 0", obs_err); end
   endtask

   task automatic test_gap_max;
      start_seq(8'd255, 4'b1111);
      observe(1030);
      n_checks++; if (obs_fall[0] != 256) begin n_fail++; $display("FAIL gapmax_fall0 got %0d want 256", obs_fall[0]); end
      n_checks++; if (obs_fall[1] != 512 || obs_fall[2] != 768 || obs_fall[3] != 1024) begin
         n_fail++; $display("FAIL gapmax_falls got %0d,%0d,%0d want 512,768,1024", obs_fall[1], obs_fall[2], obs_fall[3]);
      end
      n_checks++; if (obs_done != 1024) begin n_fail++; $display("FAIL gapmax_done got %0d want 1024", obs_done); end
      n_checks++; if (obs_err != 0)     begin n_fail++; $display("FAIL gapmax_status errors got %0d want 0", obs_err); end
   endtask

   task automatic test_mid_rst_in;
      start_seq(8'd2, 4'b1111);
      repeat (5) @(posedge CRCU_CLK);   // edges k .. k+4
      #1;
      n_checks++; if (rst_out !== 4'b1110) begin n_fail++; $display("FAIL mid_pre rst_out got %b want 1110", rst_out); end
      @(negedge CRCU_CLK);
      rst_in = 1'b1;
      @(posedge CRCU_CLK);
      #1;
      n_checks++; if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_out got %b want 1111", rst_out); end
      n_checks++; if (seq_busy !== 1'b0 || seq_done !== 1'b0) begin n_fail++; $display("FAIL mid_status busy=%b done=%b want 0/0", seq_busy, seq_done); end
      n_checks++; if (seq_stage !== 2'd0) begin n_fail++; $display("FAIL mid_stage got %0d want 0", seq_stage); end
      @(negedge CRCU_CLK);
      rst_in = 1'b0;
      observe(16);
      n_checks++; if (obs_fall[0] != 3 || obs_fall[1] != 6 || obs_fall[2] != 9 || obs_fall[3] != 12) begin
         n_fail++; $display("FAIL mid_restart_falls got %0d,%0d,%0d,%0d want 3,6,9,12", obs_fall[0], obs_fall[1], obs_fall[2], obs_fall[3]);
      end
      n_checks++; if (obs_done != 12 || obs_err != 0) begin n_fail++; $display("FAIL mid_restart_done got %0d errs %0d want 12/0", obs_done, obs_err); end
   endtask

   task automatic test_async_reset;
      start_seq(8'd2, 4'b1111);
      repeat (5) @(posedge CRCU_CLK);   // edge k+4: rst_out[0] released
      #3;
      CRCU_RST = 1'b1;
      #1;                               // still between edges
      n_checks++; if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL async_rst_out got %b want 1111", rst_out); end
      n_checks++; if (seq_busy !== 1'b0 || seq_done !== 1'b0) begin n_fail++; $display("FAIL async_status busy=%b done=%b want 0/0", seq_busy, seq_done); end
      n_checks++; if (seq_stage !== 2'd0) begin n_fail++; $display("FAIL async_stage got %0d want 0", seq_stage); end
      @(negedge CRCU_CLK);
      rst_in   = 1'b1;
      CRCU_RST = 1'b0;
      repeat (2) @(posedge CRCU_CLK);
      #1;
      n_checks++; if (rst_out !== 4'b1111 || seq_busy !== 1'b0) begin n_fail++; $display("FAIL async_hold rst_out=%b busy=%b want 1111/0", rst_out, seq_busy); end
   endtask

   task automatic test_ignored_changes;
      start_seq(8'd2, 4'b1111);
      fork
         observe(16);
         begin
            repeat (2) @(posedge CRCU_CLK);
            #2;
            seq_gap   = 8'd7;
            domain_en = 4'b0000;
         end
      join
      n_checks++; if (obs_fall[0] != 3 || obs_fall[1] != 6 || obs_fall[2] != 9 || obs_fall[3] != 12) begin
         n_fail++; $display("FAIL ign_falls got %0d,%0d,%0d,%0d want 3,6,9,12", obs_fall[0], obs_fall[1], obs_fall[2], obs_fall[3]);
      end
      n_checks++; if (obs_done != 12 || obs_err != 0) begin n_fail++; $display("FAIL ign_done got %0d errs %0d want 12/0", obs_done, obs_err); end
      // New controls take effect after the next rst_in pulse: all stages
      // disabled, one cycle each, nothing released.
      start_seq(8'd7, 4'b0000);
      observe(8);
      n_checks++; if (obs_done != 4) begin n_fail++; $display("FAIL ign_new_done got %0d want 4", obs_done); end
      n_checks++; if (rst_out !== 4'b1111) begin n_fail++; $display("FAIL ign_new_rst_out got %b want 1111", rst_out); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_full_sequence();
      test_masked();
      test_gap_zero();
      test_gap_max();
      test_mid_rst_in();
      test_async_reset();
      test_ignored_changes();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crcu_rst_sequencer.md
# crcu_rst_sequencer

Staged reset-release sequencer for the Clock & Reset Control Unit. It sits directly downstream of the synchronous reset-pulse generator and consumes that block's active-high `rst` output as `rst_in`. While `rst_in` is high it holds every peripheral reset domain in reset. Once `rst_in` falls, it releases the enabled domains one at a time, in index order, separated by a programmable gap, and reports busy/done status back to the register file.

## Interface

Parameters:
- `NUM_DOMAINS`, default 4: number of downstream reset domains (2..16).
- `GAP_W`, default 8: width of the inter-stage gap field.
- `IDX_W`, default $clog2(NUM_DOMAINS): width of the stage index.

Ports:
- `CRCU_CLK` input 1: the single clock; all logic is on its rising edge.
- `CRCU_RST` input 1: asynchronous, active-high master reset.
- `rst_in` input 1: active-high reset request from the upstream pulse generator; synchronous to `CRCU_CLK`.
- `seq_gap` input GAP_W: inter-stage gap in cycles, from the control register.
- `domain_en` input NUM_DOMAINS: per-domain enable mask.
- `rst_out` output NUM_DOMAINS: active-high per-domain resets, registered.
- `seq_busy` output 1: high while the release sequence is in progress.
- `seq_done` output 1: high once the sequence has completed; stays high until the next reset.
- `seq_stage` output IDX_W: index of the domain currently being processed.

## Operation

There are three states: HOLD, WAIT and DONE. Internal registers are `idx` (IDX_W bits), `cnt` (GAP_W bits), `gap_q` and `en_q`.

Asynchronous `CRCU_RST` forces the following immediately:
- state = HOLD
- `rst_out` = all ones
- `seq_busy` = 0, `seq_done` = 0
- `idx` = 0, `cnt` = 0, `seq_stage` = 0

**Priority rule:** `rst_in` = 1 sampled in any state takes precedence over every other transition. On that edge:
- state = HOLD
- `rst_out` = all ones
- `seq_busy` = 0, `seq_done` = 0
- `idx` = 0, `cnt` = 0

**HOLD**
- All `rst_out` are held at 1.
- When `rst_in` = 0 is sampled, the block captures `gap_q` <= `seq_gap` and `en_q` <= `domain_en`, then moves to WAIT with `idx` = 0, `cnt` = 0 and `seq_busy` = 1.

**WAIT, when `en_q[idx]` = 1**
- `cnt` increments every cycle.
- On the edge where `cnt == gap_q`, the block clears `rst_out[idx]` and advances `idx`, resetting `cnt` to 0.
- Each enabled stage therefore lasts gap_q+1 cycles.

**WAIT, when `en_q[idx]` = 0**
- The stage lasts exactly one cycle.
- `rst_out[idx]` stays at 1; `idx` advances and `cnt` = 0.

**Leaving WAIT**
- When the last stage (`idx` = NUM_DOMAINS-1) completes, the block goes to DONE on that same edge, with `seq_busy` = 0 and `seq_done` = 1.

**DONE**
- Outputs are held.
- Changes on `seq_gap` and `domain_en` are ignored; they take effect only at the next exit from HOLD.

**Other rules**
- Changes on `seq_gap` and `domain_en` during WAIT are likewise ignored, because only the captured copies are used.
- A released domain is never re-asserted, except via `rst_in` or `CRCU_RST`.
- `seq_stage` = `idx` in WAIT, 0 in HOLD, and NUM_DOMAINS-1 in DONE.
- `cnt` never wraps, since the comparison is an equality against `gap_q` and `cnt` is the same width. `gap_q` = 2^GAP_W-1 is legal and gives a stage of 2^GAP_W cycles.

## Timing

- All outputs are registered, with no combinational path from inputs to outputs.
- Let edge k be the edge that samples `rst_in` = 0 in HOLD. From edge k, `seq_busy` = 1.
- For an all-enabled mask, `rst_out[i]` falls at edge k + (i+1)(gap_q+1).
- `seq_done` rises, and `seq_busy` falls, on the same edge as the last stage completes.
- A disabled stage consumes exactly 1 cycle.
- If `rst_in` rises, every `rst_out` is back to 1 one edge after it is sampled.
- `CRCU_RST` takes effect asynchronously. On deassertion, the block is in HOLD and waits for `rst_in` = 0.

## Test plan

1. **Full sequence:** `NUM_DOMAINS`=4, `seq_gap`=2, `domain_en`=4'b1111, drop `rst_in` at edge k.
   - Required: `rst_out[0..3]` fall at edges k+3, k+6, k+9, k+12.
   - Required: `seq_done` rises at k+12, and `seq_busy` is high from k to k+11.
2. **Masked domain:** `domain_en`=4'b1101, `seq_gap`=2.
   - Required: `rst_out[0]` falls at k+3 and `rst_out[2]` at k+7.
   - Required: `rst_out[3]` falls at k+10 and `seq_done` rises at k+10.
   - Required: `rst_out[1]` stays at 1 throughout.
3. **Gap boundaries:** `seq_gap`=0 gives falls at k+1, k+2, k+3, k+4. `seq_gap`=255 gives `rst_out[0]` falling at k+256, with no early release.
4. **Mid-sequence `rst_in`:** assert `rst_in` for 1 cycle after `rst_out[0]` has fallen.
   - Required: all `rst_out` = 1, `seq_busy` = 0 and `seq_done` = 0 on the next edge.
   - Required: the sequence restarts with full timing once `rst_in` falls again.
5. **Asynchronous reset mid-sequence:** assert `CRCU_RST` between clock edges during WAIT.
   - Required: `rst_out` = 4'b1111 and the status outputs go to 0 immediately, without waiting for a clock edge.
6. **Ignored input changes:** change `seq_gap` from 2 to 7 and `domain_en` to 0 during WAIT.
   - Required: the release timing matches scenario 1 exactly.
   - Required: the new values apply only after the next `rst_in` pulse.
